// File: rtl/fitness_pkg.sv
// Shared definitions for the fitness countdown timer: FSM states, the base
// workout-time table and the gender/intensity adjustment of a base time.
package fitness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Indexed by {weight, cal}: four calorie targets per weight class.
  localparam logic [7:0] TIME_LUT [0:31] = '{
    8'd40,  8'd48,  8'd56,  8'd64,
    8'd46,  8'd55,  8'd64,  8'd73,
    8'd52,  8'd62,  8'd72,  8'd82,
    8'd58,  8'd70,  8'd82,  8'd94,
    8'd66,  8'd80,  8'd94,  8'd108,
    8'd76,  8'd92,  8'd108, 8'd124,
    8'd90,  8'd110, 8'd130, 8'd150,
    8'd120, 8'd165, 8'd210, 8'd255
  };

  function automatic logic [8:0] adjust_time(input logic [7:0] t1,
                                             input logic       gender,
                                             input logic [1:0] mode);
    logic [8:0] t2;
    t2 = gender ? ({1'b0, t1} + {4'b0000, t1[7:3]}) : {1'b0, t1};
    return t2 >> mode;
  endfunction

endpackage

// File: rtl/fitness_prescaler.sv
// Divides the clock down to one-cycle strobes, one per time unit of counting.
module fitness_prescaler #(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam logic [31:0] LAST = 32'(TICKS_PER_UNIT - 1);

  logic [31:0] r_count;

  assign o_wrap = i_en && (r_count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 32'd1;
    end
  end

endmodule

// File: rtl/fitness_countdown_timer.sv
// Workout countdown timer: accepts a configuration, derives the workout length
// from the time table, and counts it down with pause and abort support.
module fitness_countdown_timer
  import fitness_pkg::*;
#(
  parameter int          TIME_W         = 9,
  parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        weight,
  input  logic [1:0]        cal,
  input  logic [1:0]        mode,
  input  logic              gender,
  input  logic              pause,
  input  logic              abort,
  output logic [TIME_W-1:0] remaining,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_weight;
  logic [1:0]        r_cal;
  logic [1:0]        r_mode;
  logic              r_gender;
  logic [TIME_W-1:0] r_remaining;
  logic              r_done;

  logic              w_handshake;
  logic              w_abort_act;
  logic              w_count_en;
  logic              w_wrap;
  logic              w_terminal;
  logic [8:0]        w_t3;
  logic [TIME_W-1:0] w_load_val;

  assign cfg_ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy        = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign w_handshake = cfg_valid && cfg_ready;
  assign w_abort_act = abort && busy;
  // Leaving PAUSED with pause low counts that cycle, so a pause costs exactly its length.
  assign w_count_en  = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && !pause && !abort;
  assign w_terminal  = w_wrap && (r_remaining == TIME_W'(1));

  assign w_t3 = adjust_time(TIME_LUT[{r_weight, r_cal}], r_gender, r_mode);

  generate
    if (TIME_W < 9) begin : g_sat
      assign w_load_val = w_t3[8] ? '1 : w_t3[TIME_W-1:0];
    end else begin : g_ext
      assign w_load_val = TIME_W'(w_t3);
    end
  endgenerate

  fitness_prescaler #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_count_en),
    .i_clr (r_state == ST_LOAD),
    .o_wrap(w_wrap)
  );

  // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_handshake) w_next = ST_LOAD;
      ST_LOAD:   w_next = w_abort_act ? ST_IDLE : ((w_load_val == '0) ? ST_DONE : ST_RUN);
      ST_RUN, ST_PAUSED: begin
        if (w_abort_act)     w_next = ST_IDLE;
        else if (w_terminal) w_next = ST_DONE;
        else if (pause)      w_next = ST_PAUSED;
        else                 w_next = ST_RUN;
      end
      ST_DONE: begin
        if (w_handshake) w_next = ST_LOAD;
        else if (abort)  w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_weight    <= '0;
      r_cal       <= '0;
      r_mode      <= '0;
      r_gender    <= 1'b0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == ST_DONE) && (r_state != ST_DONE);
      if (w_handshake) begin
        r_weight <= weight;
        r_cal    <= cal;
        r_mode   <= mode;
        r_gender <= gender;
      end
      if (w_abort_act) begin
        r_remaining <= '0;
      end else if (r_state == ST_LOAD) begin
        r_remaining <= w_load_val;
      end else if (w_wrap && (r_remaining != '0)) begin
        r_remaining <= r_remaining - TIME_W'(1);
      end
    end
  end

  assign remaining = r_remaining;
  assign done      = r_done;

endmodule

// File: tb/tb_fitness_countdown_timer.sv
// Self-checking bench: table of workout configurations plus hand-written
// pause, abort and reset sequences, run on 9-bit and 8-bit builds in parallel.
module tb_fitness_countdown_timer;

  localparam int TICKS = 4;
  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, gender, pause, abort;
  logic [2:0] weight;
  logic [1:0] cal, mode;

  logic       cfg_ready, busy, done;
  logic [8:0] remaining;
  logic       cfg_ready8, busy8, done8;
  logic [7:0] remaining8;

  always #5 clk = ~clk;

  fitness_countdown_timer #(.TIME_W(9), .TICKS_PER_UNIT(TICKS)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .weight(weight), .cal(cal), .mode(mode), .gender(gender),
    .pause(pause), .abort(abort), .remaining(remaining), .busy(busy), .done(done)
  );

  fitness_countdown_timer #(.TIME_W(8), .TICKS_PER_UNIT(TICKS)) dut8 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready8),
    .weight(weight), .cal(cal), .mode(mode), .gender(gender),
    .pause(pause), .abort(abort), .remaining(remaining8), .busy(busy8), .done(done8)
  );

  typedef struct {
    int idx;
    int gender;
    int mode;
    int exp_rem;
    int exp_rem8;
    int exp_lat;
  } vec_t;

  typedef struct {
    int rem;
    int rem8;
    int lat;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one handshake; the caller leaves the bench in the LOAD cycle.
  task automatic offer(input vec_t v, input logic with_abort);
    exp_t e;
    weight    = 3'(v.idx >> 2);
    cal       = 2'(v.idx & 3);
    gender    = 1'(v.gender);
    mode      = 2'(v.mode);
    cfg_valid = 1'b1;
    abort     = with_abort;
    e.rem = v.exp_rem; e.rem8 = v.exp_rem8; e.lat = v.exp_lat;
    sb_q.push_back(e);
    step();
    cfg_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic check_load(input string name, output exp_t e);
    step();
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
      n_total++;
      e.rem = -1; e.rem8 = -1; e.lat = -1;
    end else begin
      e = sb_q.pop_front();
      check({name, " remaining"}, int'(remaining), e.rem);
      check({name, " remaining8"}, int'(remaining8), e.rem8);
    end
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done) pulses++;
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    int   pulses;

    vecs[0] = '{0,  0, 0, 40,  40,  160};
    vecs[1] = '{0,  1, 2, 11,  11,  44};
    vecs[2] = '{0,  0, 3, 5,   5,   20};
    vecs[3] = '{0,  1, 1, 22,  22,  88};
    vecs[4] = '{31, 0, 1, 127, 127, 508};
    vecs[5] = '{31, 1, 3, 35,  35,  140};
    vecs[6] = '{31, 1, 0, 286, 255, 1144};
    vecs[7] = '{31, 0, 0, 255, 255, 1020};

    rst = 1'b1; cfg_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    weight = '0; cal = '0; mode = '0; gender = 1'b0;
    step(); step();
    check("reset remaining", int'(remaining), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset cfg_ready", int'(cfg_ready), 1);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      offer(vecs[i], 1'b0);
      check($sformatf("vec%0d load busy", i), int'(busy), 1);
      check_load($sformatf("vec%0d", i), e);
      n = 0;
      wait_done(n);
      check($sformatf("vec%0d latency", i), n, e.lat);
      check($sformatf("vec%0d done remaining", i), int'(remaining), 0);
      check($sformatf("vec%0d done cfg_ready", i), int'(cfg_ready), 1);
      check($sformatf("vec%0d done busy", i), int'(busy), 0);
      step();
      check($sformatf("vec%0d done pulse width", i), int'(done), 0);
    end

    // Handshake and abort together in DONE: the handshake wins.
    offer(vecs[1], 1'b1);
    check("done cfg+abort busy", int'(busy), 1);
    check_load("done cfg+abort", e);
    abort = 1'b1; step(); abort = 1'b0;
    check("run abort remaining", int'(remaining), 0);
    check("run abort cfg_ready", int'(cfg_ready), 1);
    count_done(60, pulses);
    check("run abort no done", pulses, 0);

    // Pause for ten cycles mid-run.
    offer(vecs[0], 1'b0);
    check_load("pause", e);
    n = 0;
    for (int i = 0; i < 30; i++) begin step(); n++; end
    check("pause pre remaining", int'(remaining), 33);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); n++; end
    check("pause frozen remaining", int'(remaining), 33);
    check("pause busy", int'(busy), 1);
    check("pause done", int'(done), 0);
    pause = 1'b0;
    wait_done(n);
    check("pause latency", n, 170);
    step();

    // Abort on the cycle that would take remaining from 1 to 0.
    offer(vecs[2], 1'b0);
    check_load("abort terminal", e);
    for (int i = 0; i < 19; i++) step();
    check("abort terminal pre remaining", int'(remaining), 1);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort terminal remaining", int'(remaining), 0);
    check("abort terminal done", int'(done), 0);
    check("abort terminal busy", int'(busy), 0);
    check("abort terminal cfg_ready", int'(cfg_ready), 1);
    offer(vecs[3], 1'b0);
    check("abort then cfg busy", int'(busy), 1);
    check_load("abort then cfg", e);

    // Reset mid-run with twenty units left.
    for (int i = 0; i < 8; i++) step();
    check("rst pre remaining", int'(remaining), 20);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst mid remaining", int'(remaining), 0);
    check("rst mid cfg_ready", int'(cfg_ready), 1);
    check("rst mid busy", int'(busy), 0);
    check("rst mid done", int'(done), 0);
    count_done(150, pulses);
    check("rst mid no done", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
